// File: rtl/com_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : com_bus_arbiter
// Description : Round-robin arbiter for the shared cache-wrapper common bus,
//               with one-cycle turnaround between owners and a hold monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module com_bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Com_Bus_Req,
    output logic [3:0] Com_Bus_Gnt,
    output logic [1:0] Bus_Owner,
    output logic       Bus_Busy,
    output logic       Hold_Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] C_MAX_HOLD = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] C_PRE_MAX  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] C_ONE      = HOLD_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [3:0]        w_gnt_nxt;
    logic [1:0]        w_owner_nxt;
    logic              w_busy_nxt;
    logic              w_timeout_nxt;

    // Round-robin search: rotate requests so the slot after the owner is bit 0
    logic [7:0] w_req_dbl;
    logic [1:0] w_start;
    logic [3:0] w_req_rot;
    logic [1:0] w_off;
    logic [1:0] w_winner;

    assign w_req_dbl = {Com_Bus_Req, Com_Bus_Req};
    assign w_start   = Bus_Owner + 2'd1;
    assign w_req_rot = 4'(w_req_dbl >> w_start);

    always_comb begin
        w_off = 2'd3;
        if (w_req_rot[0])      w_off = 2'd0;
        else if (w_req_rot[1]) w_off = 2'd1;
        else if (w_req_rot[2]) w_off = 2'd2;
    end

    assign w_winner = w_start + w_off;

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = Com_Bus_Gnt;
        w_owner_nxt    = Bus_Owner;
        w_busy_nxt     = Bus_Busy;
        w_timeout_nxt  = 1'b0;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            ST_IDLE, ST_TURN: begin
                if (|Com_Bus_Req) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = 4'b0001 << w_winner;
                    w_owner_nxt    = w_winner;
                    w_busy_nxt     = 1'b1;
                    w_hold_cnt_nxt = C_ONE;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_gnt_nxt      = 4'b0000;
                    w_busy_nxt     = 1'b0;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (Com_Bus_Req[Bus_Owner]) begin
                    // Saturating count; the pulse fires only on the step into MAX_HOLD
                    if (r_hold_cnt != C_MAX_HOLD) w_hold_cnt_nxt = r_hold_cnt + C_ONE;
                    w_timeout_nxt = (r_hold_cnt == C_PRE_MAX);
                end else begin
                    w_state_nxt    = ST_TURN;
                    w_gnt_nxt      = 4'b0000;
                    w_busy_nxt     = 1'b0;
                    w_hold_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_gnt_nxt      = 4'b0000;
                w_busy_nxt     = 1'b0;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    // Owner resets to 3 so the first search starts at core 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            Com_Bus_Gnt  <= 4'b0000;
            Bus_Owner    <= 2'd3;
            Bus_Busy     <= 1'b0;
            Hold_Timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            Com_Bus_Gnt  <= w_gnt_nxt;
            Bus_Owner    <= w_owner_nxt;
            Bus_Busy     <= w_busy_nxt;
            Hold_Timeout <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_com_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_com_bus_arbiter
// Description : Self-checking bench for com_bus_arbiter: vector table, corner
//               sequences and randomized traffic against a tenure-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_com_bus_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus and how long the tenure has lasted
    bit         m_active;
    int         m_owner;
    int         m_tenure;
    logic [3:0] prev_gnt;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[15];

    com_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .Com_Bus_Req (req),
        .Com_Bus_Gnt (gnt),
        .Bus_Owner   (owner),
        .Bus_Busy    (busy),
        .Hold_Timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        logic [3:0] e_gnt;
        rst = r;
        req = q;
        @(posedge clk);
        #1;
        if (r) begin
            m_active = 1'b0;
            m_owner  = 3;
            m_tenure = 0;
        end else if (m_active) begin
            if (q[m_owner]) m_tenure++;
            else begin
                m_active = 1'b0;
                m_tenure = 0;
            end
        end else if (q != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (!m_active && q[(m_owner + k) % 4]) begin
                    m_active = 1'b1;
                    m_owner  = (m_owner + k) % 4;
                    m_tenure = 1;
                end
            end
        end
        e_gnt = m_active ? (4'b0001 << m_owner) : 4'b0000;
        chk("model_gnt", gnt, e_gnt);
        chk("model_owner", owner, m_owner);
        chk("model_busy", busy, m_active);
        chk("model_timeout", timeout, m_active && (m_tenure == MAX_HOLD));
        chk("onehot_gnt", $countones(gnt) <= 1, 1);
        chk("no_direct_handover", (prev_gnt != 0 && gnt != 0 && gnt != prev_gnt), 0);
        prev_gnt = gnt;
    endtask

    initial begin
        logic [3:0] q;
        int         o;
        prev_gnt = 4'b0000;
        m_active = 1'b0;
        m_owner  = 3;
        m_tenure = 0;

        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0010, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].req);
            chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
            chk($sformatf("vec%0d_owner", i), owner, vecs[i].owner);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_timeout", i), timeout, vecs[i].to);
        end

        // All four request; each owner keeps the bus three cycles then drops once
        step(1'b1, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            o = k % 4;
            step(1'b0, 4'b1111);
            chk("rr_grant", gnt, 4'b0001 << o);
            step(1'b0, 4'b1111);
            step(1'b0, 4'b1111);
            chk("rr_hold", gnt, 4'b0001 << o);
            step(1'b0, 4'b1111 & ~(4'b0001 << o));
            chk("rr_gap", gnt, 4'b0000);
        end

        // Single long requester: timeout pulses once, grant never drops
        step(1'b1, 4'b0000);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 4'b0100);
            chk("hold_gnt", gnt, 4'b0100);
            chk("hold_pulse", timeout, (i == MAX_HOLD));
        end

        // Reset in the middle of core 2's tenure
        step(1'b1, 4'b0100);
        chk("midrst_gnt", gnt, 4'b0000);
        chk("midrst_owner", owner, 2'd3);
        step(1'b0, 4'b0101);
        chk("postrst_gnt", gnt, 4'b0001);

        // No preemption: core 3 waits for core 1 to release
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1010);
            chk("nopreempt_gnt", gnt, 4'b0010);
        end
        step(1'b0, 4'b1000);
        chk("nopreempt_turn", gnt, 4'b0000);
        step(1'b0, 4'b1000);
        chk("nopreempt_next", gnt, 4'b1000);

        // Randomized traffic with sticky requests so tenures run long enough to time out
        q = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) q[b] = ~q[b];
            step($urandom_range(63) == 0, q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
